manchester_rx: RTL and testbench

Oversampling Manchester receiver placed directly downstream of the Manchester encoder. It recovers bit timing from mid-bit transitions on the serial line, hunts for a start-of-frame delimiter, and deserialises the following data into DW-bit words with a one-cycle valid strobe. It detects missing transitions and flags them as code violations.

---
 rtl/manchester_rx.sv | 146 ++++++++++++++
 tb/tb_manchester_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_rx.sv
// Oversampling Manchester receiver: recovers bit timing from mid-bit transitions,
// hunts for the start-of-frame delimiter, then deserialises DW-bit words.
// Window limits are measured in clk cycles between successive detected edges,
// so a mid-bit spacing of exactly 3*OVS/4 .. 5*OVS/4 cycles is accepted.
module manchester_rx #(
    parameter int unsigned   OVS = 8,
    parameter int unsigned   DW  = 8,
    parameter logic [DW-1:0] SFD = 8'hD5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          line_in,
    input  logic          rx_en,
    output logic [DW-1:0] d_out,
    output logic          d_valid,
    output logic          sync_lock,
    output logic          code_err
);

    localparam int unsigned CntW = $clog2(2 * OVS) + 1;
    localparam int unsigned BcW  = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [CntW:0]  MidLo  = (CntW + 1)'(3 * OVS / 4);
    localparam logic [CntW:0]  MidHi  = (CntW + 1)'(5 * OVS / 4);
    localparam logic [BcW-1:0] BcLast = BcW'(DW - 1);

    typedef enum logic [1:0] {StIdle, StHunt, StData} state_e;

    state_e          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   sh_q, sh_d;
    logic [BcW-1:0]  bcnt_q, bcnt_d;
    logic [DW-1:0]   d_out_q, d_out_d;
    logic            d_valid_q, d_valid_d;
    logic            code_err_q, code_err_d;

    logic            line_edge;
    logic            rx_bit;
    logic [CntW:0]   since;
    logic            mid_edge;
    logic            timeout;
    logic [DW-1:0]   sh_shift;

    assign line_edge = s2_q ^ s3_q;
    assign rx_bit    = s2_q;
    // Cycles elapsed since the last accepted mid-bit edge, counting this one.
    assign since     = {1'b0, cnt_q} + 1'b1;
    assign mid_edge  = line_edge && (since >= MidLo) && (since <= MidHi);
    assign timeout   = (since > MidHi);
    assign sh_shift  = {rx_bit, sh_q[DW-1:1]};

    // Next-state, shift register, word assembly and strobe generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        sh_d       = sh_q;
        bcnt_d     = bcnt_q;
        d_out_d    = d_out_q;
        d_valid_d  = 1'b0;
        code_err_d = 1'b0;

        if (!rx_en) begin
            // Disable wins over everything, including a coincident timeout.
            state_d = StIdle;
            sh_d    = '0;
            bcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sh_d   = '0;
                    bcnt_d = '0;
                    // Preamble starts with a 1, so the first edge is a mid-bit edge.
                    if (line_edge) begin
                        state_d = StHunt;
                        sh_d    = {rx_bit, {(DW - 1){1'b0}}};
                        cnt_d   = '0;
                    end
                end
                StHunt: begin
                    if (timeout) begin
                        state_d = StIdle;
                    end else if (mid_edge) begin
                        cnt_d = '0;
                        sh_d  = sh_shift;
                        if (sh_shift == SFD) begin
                            state_d = StData;
                            bcnt_d  = '0;
                        end
                    end
                end
                StData: begin
                    if (timeout) begin
                        // Silence on a word boundary is a normal end of frame.
                        state_d    = StIdle;
                        code_err_d = (bcnt_q != '0);
                    end else if (mid_edge) begin
                        cnt_d = '0;
                        sh_d  = sh_shift;
                        if (bcnt_q == BcLast) begin
                            d_out_d   = sh_shift;
                            d_valid_d = 1'b1;
                            bcnt_d    = '0;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Input synchroniser and all receiver state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            sh_q       <= '0;
            bcnt_q     <= '0;
            d_out_q    <= '0;
            d_valid_q  <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            s1_q       <= line_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            bcnt_q     <= bcnt_d;
            d_out_q    <= d_out_d;
            d_valid_q  <= d_valid_d;
            code_err_q <= code_err_d;
        end
    end

    assign d_out     = d_out_q;
    assign d_valid   = d_valid_q;
    assign code_err  = code_err_q;
    assign sync_lock = (state_q == StData);

endmodule

// File: tb/tb_manchester_rx.sv
// Scoreboard bench for manchester_rx: stimulus pushes expected words / errors,
// a negedge monitor pops and compares whenever the receiver strobes.
module tb_manchester_rx;

    localparam int unsigned OVS = 8;
    localparam int unsigned DW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          line_in;
    logic          rx_en;
    logic [DW-1:0] d_out;
    logic          d_valid;
    logic          sync_lock;
    logic          code_err;

    manchester_rx #(
        .OVS(OVS),
        .DW (DW),
        .SFD(8'hD5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_in  (line_in),
        .rx_en    (rx_en),
        .d_out    (d_out),
        .d_valid  (d_valid),
        .sync_lock(sync_lock),
        .code_err (code_err)
    );

    always #5 clk = ~clk;

    int         n_cmp     = 0;
    int         n_bad     = 0;
    logic [7:0] exp_q[$];
    int         exp_cerr  = 0;
    bit         lock_seen = 1'b0;
    bit         bits_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected at %0t", name, $time);
    endtask

    // Monitor: compare every strobe against the scoreboard.
    initial begin
        int   cyc       = 0;
        int   last_dv   = -1000;
        logic prev_dv   = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (sync_lock) lock_seen = 1'b1;
                if (d_valid) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected d_valid");
                    end else begin
                        e = exp_q.pop_front();
                        check("d_out word", 32'(d_out), 32'(e));
                    end
                    check("d_valid one cycle", 32'(prev_dv), 32'd0);
                    if (cyc - last_dv < 200) check("word spacing", cyc - last_dv, 64);
                    last_dv = cyc;
                end
                if (code_err) begin
                    if (exp_cerr == 0) begin
                        fail("unexpected code_err");
                    end else begin
                        exp_cerr--;
                        check("sync_lock low with code_err", 32'(sync_lock), 32'd0);
                    end
                end
                prev_dv = d_valid;
            end else begin
                prev_dv = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
    endtask

    task automatic half(input logic v, input int n);
        line_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        half(1'b0, n);
    endtask

    // Sends queued bits; jit alternates 6/10-cycle mid-bit spacing, abort_idx pulses
    // rx_en low inside that bit, stop_idx truncates the stream (line holds its level).
    task automatic send_bits(input bit jit, input int abort_idx, input int stop_idx);
        for (int i = 0; i < bits_q.size(); i++) begin
            int   h1;
            int   h2;
            logic b;
            if (i == stop_idx) break;
            b  = bits_q[i];
            h1 = !jit ? 4 : ((i % 2 == 0) ? 5 : 3);
            h2 = 8 - h1;
            if (i == abort_idx) begin
                line_in = !b;
                @(posedge clk);
                #1 rx_en = 1'b0;
                @(posedge clk);
                #1 rx_en = 1'b1;
                repeat (h1 - 2) @(posedge clk);
                #1;
            end else begin
                half(!b, h1);
            end
            half(b, h2);
        end
        bits_q.delete();
    endtask

    initial begin
        rst     = 1'b1;
        line_in = 1'b0;
        rx_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset d_out", 32'(d_out), 32'd0);
        check("reset d_valid", 32'(d_valid), 32'd0);
        check("reset sync_lock", 32'(sync_lock), 32'd0);
        check("reset code_err", 32'(code_err), 32'd0);
        rst = 1'b0;
        idle(10);

        // Nominal frame.
        push_byte(8'h55); push_byte(8'h55); push_byte(8'hD5);
        send_bits(1'b0, -1, -1);
        check("lock after SFD", 32'(sync_lock), 32'd1);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h3C);
        push_byte(8'hA3); push_byte(8'h3C);
        send_bits(1'b0, -1, -1);
        idle(40);
        check("frame words consumed", exp_q.size(), 0);
        check("lock drops at end of frame", 32'(sync_lock), 32'd0);
        check("d_out held", 32'(d_out), 32'h3C);

        // Code violation: line goes quiet after 3 bits of 0xA3.
        exp_cerr = 1;
        push_byte(8'h55); push_byte(8'h55); push_byte(8'hD5); push_byte(8'hA3);
        send_bits(1'b0, -1, 27);
        idle(40);
        check("violation code_err seen", exp_cerr, 0);
        check("violation lock low", 32'(sync_lock), 32'd0);
        check("violation d_out unchanged", 32'(d_out), 32'h3C);

        // Jitter: mid-bit spacing alternates 6 and 10 cycles.
        exp_q.push_back(8'hA3); exp_q.push_back(8'h3C);
        push_byte(8'h55); push_byte(8'h55); push_byte(8'hD5);
        push_byte(8'hA3); push_byte(8'h3C);
        send_bits(1'b1, -1, -1);
        idle(40);
        check("jitter words consumed", exp_q.size(), 0);

        // Enable abort mid-word, then a fresh frame.
        push_byte(8'h55); push_byte(8'h55); push_byte(8'hD5); push_byte(8'hA3);
        send_bits(1'b0, 27, -1);
        idle(40);
        check("abort lock low", 32'(sync_lock), 32'd0);
        check("abort d_out unchanged", 32'(d_out), 32'h3C);
        exp_q.push_back(8'h5A);
        push_byte(8'h55); push_byte(8'h55); push_byte(8'hD5); push_byte(8'h5A);
        send_bits(1'b0, -1, -1);
        idle(40);
        check("fresh frame consumed", exp_q.size(), 0);
        check("fresh frame d_out", 32'(d_out), 32'h5A);

        // Preamble only: never locks.
        lock_seen = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h55);
        send_bits(1'b0, -1, -1);
        idle(40);
        check("no SFD never locks", 32'(lock_seen), 32'd0);

        // Asynchronous reset in DATA, then a clean frame.
        push_byte(8'h55); push_byte(8'h55); push_byte(8'hD5); push_byte(8'hA3);
        send_bits(1'b0, -1, 27);
        check("locked before reset", 32'(sync_lock), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async rst d_out", 32'(d_out), 32'd0);
        check("async rst d_valid", 32'(d_valid), 32'd0);
        check("async rst sync_lock", 32'(sync_lock), 32'd0);
        check("async rst code_err", 32'(code_err), 32'd0);
        line_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(20);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h3C);
        push_byte(8'h55); push_byte(8'h55); push_byte(8'hD5);
        push_byte(8'hA3); push_byte(8'h3C);
        send_bits(1'b0, -1, -1);
        idle(40);
        check("post-reset frame consumed", exp_q.size(), 0);
        check("no pending code_err", exp_cerr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
